// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared types and constants for the instruction-fetch PC unit
package fetch_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_JMP  = 2'd2,
        RD_EXC  = 2'd3
    } redir_t;

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// rtl/fetch_pc_unit_if_id_reg.sv - IF/ID pipeline register with load enable and clear-valid
module if_id_reg
    import fetch_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_clr_valid,
    input  logic [WORD_W-1:0] i_pc,
    input  logic [WORD_W-1:0] i_pc4,
    input  logic [WORD_W-1:0] i_instr,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_pc4,
    output logic [WORD_W-1:0] o_instr,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_pc4;
    logic [WORD_W-1:0] r_instr;
    logic              r_valid;

    // Clear-valid wins over load so a flush can never be overwritten by a same-cycle fill
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (i_clr_valid) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register, next-PC select, stall buffer and fetch FSM
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_PC   = 32'h0000_0080
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] PC_OUT,
    input  logic [31:0] PC_PLUS4,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        JMP,
    input  logic [31:0] JMP_TARGET,
    input  logic        EXC,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    input  logic        IMEM_ACK,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_INSTR,
    output logic        IF_ID_VALID
);

    state_t            r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_buf;
    logic [WORD_W-1:0] r_buf_pc4;

    redir_t            w_redir_sel;
    logic [WORD_W-1:0] w_redir_target;
    logic              w_redirect;
    logic              w_load;
    logic              w_clr_valid;
    logic [WORD_W-1:0] w_ld_pc4;
    logic [WORD_W-1:0] w_ld_instr;

    // Redirect priority: exception, then jump, then branch
    always_comb begin
        w_redir_sel    = RD_NONE;
        w_redir_target = r_pc;
        if (EXC) begin
            w_redir_sel    = RD_EXC;
            w_redir_target = EXC_PC;
        end else if (JMP) begin
            w_redir_sel    = RD_JMP;
            w_redir_target = JMP_TARGET;
        end else if (BR_TAKEN) begin
            w_redir_sel    = RD_BR;
            w_redir_target = BR_TARGET;
        end
    end

    // Redirects only take effect once the FSM has left IDLE
    always_comb begin
        w_redirect = (r_state != IDLE) && (w_redir_sel != RD_NONE);
    end

    // IF/ID fill and flush control; HOLD replays the buffered word, FETCH forwards memory data
    always_comb begin
        w_load      = 1'b0;
        w_clr_valid = 1'b0;
        w_ld_pc4    = PC_PLUS4;
        w_ld_instr  = IMEM_RDATA;
        if (w_redirect) begin
            w_clr_valid = 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (IMEM_ACK && !STALL) begin
                        w_load = 1'b1;
                    end else if (!IMEM_ACK && !STALL) begin
                        w_clr_valid = 1'b1;
                    end
                end
                HOLD: begin
                    w_ld_pc4   = r_buf_pc4;
                    w_ld_instr = r_buf;
                    if (!STALL) begin
                        w_load = 1'b1;
                    end
                end
                default: begin
                    w_load      = 1'b0;
                    w_clr_valid = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM with PC register and stall buffer
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_buf     <= '0;
            r_buf_pc4 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (w_redirect) begin
                        r_pc    <= w_redir_target;
                        r_state <= FETCH;
                    end else if (IMEM_ACK && !STALL) begin
                        r_pc <= PC_PLUS4;
                    end else if (IMEM_ACK && STALL) begin
                        r_buf     <= IMEM_RDATA;
                        r_buf_pc4 <= PC_PLUS4;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pc      <= w_redir_target;
                        r_buf     <= '0;
                        r_buf_pc4 <= '0;
                        r_state   <= FETCH;
                    end else if (!STALL) begin
                        r_pc    <= r_buf_pc4;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_load      (w_load),
        .i_clr_valid (w_clr_valid),
        .i_pc        (r_pc),
        .i_pc4       (w_ld_pc4),
        .i_instr     (w_ld_instr),
        .o_pc        (IF_ID_PC),
        .o_pc4       (IF_ID_PC4),
        .o_instr     (IF_ID_INSTR),
        .o_valid     (IF_ID_VALID)
    );

    assign PC_OUT    = r_pc;
    assign IMEM_ADDR = r_pc;
    assign IMEM_REQ  = (r_state == FETCH);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] PC_OUT;
    logic [31:0] PC_PLUS4 = '0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] BR_TARGET = '0;
    logic        JMP = 1'b0;
    logic [31:0] JMP_TARGET = '0;
    logic        EXC = 1'b0;
    logic        STALL = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA = '0;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_INSTR;
    logic        IF_ID_VALID;

    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    fetch_pc_unit #(.RESET_PC(32'h0), .EXC_PC(EXC_VEC)) dut (
        .CLK(CLK), .RST_N(RST_N), .PC_OUT(PC_OUT), .PC_PLUS4(PC_PLUS4),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .JMP(JMP), .JMP_TARGET(JMP_TARGET),
        .EXC(EXC), .STALL(STALL), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RDATA(IMEM_RDATA), .IMEM_ACK(IMEM_ACK), .IF_ID_PC(IF_ID_PC),
        .IF_ID_PC4(IF_ID_PC4), .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_VALID(IF_ID_VALID)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the decode stage should see and where fetch should point
    logic        m_known = 1'b0;
    logic        m_starting;
    logic        m_parked;
    logic [31:0] m_pc, m_park_instr, m_park_pc4;
    logic [31:0] m_id_pc, m_id_pc4, m_id_instr;
    logic        m_id_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, stall, br, jmp, exc, ack,
                              input logic [31:0] bt, jt);
        logic [31:0] tgt;
        if (!rst) begin
            m_known = 1'b1; m_starting = 1'b1; m_parked = 1'b0;
            m_pc = 32'h0; m_park_instr = '0; m_park_pc4 = '0;
            m_id_pc = '0; m_id_pc4 = '0; m_id_instr = '0; m_id_valid = 1'b0;
        end else if (!m_known) begin
            // nothing defined before the first reset
        end else if (m_starting) begin
            m_starting = 1'b0;
        end else if (exc || jmp || br) begin
            tgt = exc ? EXC_VEC : (jmp ? jt : bt);
            m_pc = tgt; m_id_valid = 1'b0; m_parked = 1'b0;
        end else if (m_parked) begin
            if (!stall) begin
                m_id_pc = m_pc; m_id_pc4 = m_park_pc4; m_id_instr = m_park_instr;
                m_id_valid = 1'b1; m_pc = m_park_pc4; m_parked = 1'b0;
            end
        end else if (ack) begin
            if (stall) begin
                m_park_instr = mem_word(m_pc); m_park_pc4 = m_pc + 32'd4; m_parked = 1'b1;
            end else begin
                m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_instr = mem_word(m_pc);
                m_id_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else if (!stall) begin
            m_id_valid = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, compare registered outputs, advance the model
    task automatic step(input logic rst, stall, br, jmp, exc, ack_en,
                        input logic [31:0] bt, jt);
        @(negedge CLK);
        RST_N = rst; STALL = stall; BR_TAKEN = br; JMP = jmp; EXC = exc;
        BR_TARGET = bt; JMP_TARGET = jt;
        PC_PLUS4 = PC_OUT + 32'd4;
        IMEM_RDATA = mem_word(IMEM_ADDR);
        IMEM_ACK = ack_en & IMEM_REQ;
        if (m_known) begin
            chk("pc_out", PC_OUT, m_pc);
            chk("imem_addr", IMEM_ADDR, m_pc);
            chk("imem_req", {31'b0, IMEM_REQ}, {31'b0, m_known && !m_starting && !m_parked});
            chk("if_id_valid", {31'b0, IF_ID_VALID}, {31'b0, m_id_valid});
            chk("if_id_pc", IF_ID_PC, m_id_pc);
            chk("if_id_pc4", IF_ID_PC4, m_id_pc4);
            chk("if_id_instr", IF_ID_INSTR, m_id_instr);
        end
        model_edge(rst, stall, br, jmp, exc, IMEM_ACK, bt, jt);
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset and start
        repeat (3) step(1'b0, 0, 0, 0, 0, 1, 0, 0);
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("start_first_req", {31'b0, IMEM_REQ}, 32'd1);
        chk("start_first_addr", IMEM_ADDR, 32'h0);
        repeat (2) step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("start_ifid_pc", IF_ID_PC, 32'h4);
        chk("start_addr3", IMEM_ADDR, 32'h8);
        // wait states at 0x8
        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("wait_bubble", {31'b0, IF_ID_VALID}, 32'd0);
        chk("wait_addr", IMEM_ADDR, 32'h8);
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("wait_ifid_pc", IF_ID_PC, 32'h8);

        // stall during ACK, from a fresh start
        step(1'b0, 0, 0, 0, 0, 1, 0, 0);
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) step(1'b1, 1, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("stall_hold_pc", IF_ID_PC, 32'h0);
        chk("stall_no_req", {31'b0, IMEM_REQ}, 32'd0);
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("stall_release_pc", IF_ID_PC, 32'h4);
        chk("stall_release_instr", IF_ID_INSTR, mem_word(32'h4));
        chk("stall_release_pcout", PC_OUT, 32'h8);

        // redirect priority
        step(1'b1, 0, 1, 1, 0, 1, 32'h100, 32'h200);
        after_edge();
        chk("prio_jmp", PC_OUT, 32'h200);
        chk("prio_jmp_valid", {31'b0, IF_ID_VALID}, 32'd0);
        step(1'b1, 0, 1, 1, 1, 1, 32'h100, 32'h200);
        after_edge();
        chk("prio_exc", PC_OUT, 32'h80);

        // redirect while holding a stalled instruction
        step(1'b1, 1, 0, 0, 0, 1, 0, 0);
        step(1'b1, 1, 1, 0, 0, 1, 32'h40, 0);
        after_edge();
        chk("hold_redir_pc", PC_OUT, 32'h40);
        chk("hold_redir_valid", {31'b0, IF_ID_VALID}, 32'd0);
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("hold_redir_ifid", IF_ID_PC, 32'h40);

        // wrap-around of the PC
        step(1'b1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("wrap_pc", PC_OUT, 32'h0);
        chk("wrap_ifid_pc4", IF_ID_PC4, 32'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r_rst, r_stall, r_br, r_jmp, r_exc, r_ack;
            r_rst   = ($urandom_range(0, 99) != 0);
            r_stall = ($urandom_range(0, 99) < 30);
            r_br    = ($urandom_range(0, 99) < 8);
            r_jmp   = ($urandom_range(0, 99) < 5);
            r_exc   = ($urandom_range(0, 99) < 3);
            r_ack   = ($urandom_range(0, 99) < 70);
            step(r_rst, r_stall, r_br, r_jmp, r_exc, r_ack, $urandom, $urandom);
        end
        step(1'b1, 0, 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch control stage: owns the program-counter register and the IF/ID pipeline register. Each cycle it presents the current PC to the PC+4 incrementer and to instruction memory. It selects the next PC from PC+4, the branch target, the jump target or the exception vector. It handles variable-latency memory responses, ID stalls and control-flow flushes, and feeds the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_PC, 32'h0000_0080, exception redirect target

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous, active-low reset
- PC_OUT  out  32  current PC register; drives the incrementer and IMEM_ADDR
- PC_PLUS4  in  32  incrementer result, PC_OUT+4
- BR_TAKEN  in  1  branch redirect request
- BR_TARGET  in  32  branch target
- JMP  in  1  jump redirect request
- JMP_TARGET  in  32  jump target
- EXC  in  1  exception redirect request
- STALL  in  1  decode hazard; hold IF/ID contents
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  32  fetch address, equal to PC_OUT
- IMEM_RDATA  in  32  fetched instruction, valid when IMEM_ACK=1
- IMEM_ACK  in  1  response strobe; may arrive in the same cycle as IMEM_REQ
- IF_ID_PC  out  32  PC of the instruction in IF/ID
- IF_ID_PC4  out  32  PC+4 of the instruction in IF/ID
- IF_ID_INSTR  out  32  instruction in IF/ID
- IF_ID_VALID  out  1  IF/ID holds a real instruction; 0 means bubble

## Operation
- The block has three states: IDLE, FETCH and HOLD.
- The registered instruction buffer BUF holds an instruction that was received while STALL was high. BUF_PC4 holds its PC+4.
- IMEM_REQ is 1 exactly when state is FETCH.
- IMEM_ADDR equals PC_OUT combinationally.
- The memory samples the address every cycle. It keeps no outstanding-request state, so changing the address abandons the previous request.

State transitions:
- **IDLE** goes to FETCH unconditionally on the next cycle.
- **FETCH** with IMEM_ACK=1 and STALL=0:
  - IF_ID_PC ← PC_OUT
  - IF_ID_PC4 ← PC_PLUS4
  - IF_ID_INSTR ← IMEM_RDATA
  - IF_ID_VALID ← 1
  - PC ← PC_PLUS4
  - Stay in FETCH.
- **FETCH** with IMEM_ACK=1 and STALL=1:
  - BUF ← IMEM_RDATA and BUF_PC4 ← PC_PLUS4.
  - IF/ID and PC hold.
  - Go to HOLD.
- **FETCH** with IMEM_ACK=0: everything holds. IF_ID_VALID is unchanged if STALL=1 and is cleared to 0 otherwise; the bubble drains.
- **HOLD** with STALL=1: everything holds.
- **HOLD** with STALL=0:
  - IF/ID ← {PC_OUT, BUF_PC4, BUF, valid=1}
  - PC ← BUF_PC4
  - Go to FETCH.

Redirects:
- Priority is EXC, then JMP, then BR_TAKEN. The target is EXC_PC, JMP_TARGET or BR_TARGET respectively.
- A redirect is honoured in FETCH and HOLD. It overrides STALL and every action listed above:
  - PC ← target
  - IF_ID_VALID ← 0 (the other IF/ID fields hold)
  - BUF is discarded
  - state ← FETCH
- An IMEM_ACK in the same cycle as a redirect is ignored.
- A redirect in IDLE is ignored.

Width rules:
- All PC arithmetic is 32-bit, done externally, and wraps modulo 2^32.
- Targets are used as-is, with no alignment check.

## Timing
- Reset is sampled on the CLK edge. With RST_N=0:
  - PC_OUT = RESET_PC
  - IF_ID_PC, IF_ID_PC4 and IF_ID_INSTR = 0
  - IF_ID_VALID = 0
  - BUF = 0
  - state = IDLE, so IMEM_REQ = 0
- Reset asserted mid-operation aborts everything on the next edge, including a pending BUF.
- First IMEM_REQ is in the second cycle after RST_N rises: IDLE for one cycle, then FETCH.
- Latency, ACK to IF/ID: 1 cycle, since IF/ID is registered on the ACK edge.
- Throughput with zero-wait memory is 1 instruction per cycle.
- Redirect to first request at the target: the request is issued the cycle after the redirect edge.
- HOLD adds no refetch. The buffered instruction enters IF/ID on the first edge where STALL=0.

## Structure
- Shared package fetch_pkg contains:
  - the state enum {IDLE, FETCH, HOLD}
  - a redirect-select enum {RD_NONE, RD_BR, RD_JMP, RD_EXC}
  - the 32-bit word width constant
- One sub-module, if_id_reg, implements the IF/ID register. It has load enable, clear-valid and synchronous active-low reset.
- The FSM, PC register, BUF and redirect mux live in the top level.

## Test plan
- **Reset and start:** hold RST_N=0 for 3 cycles, then release with ACK tied to REQ.
  - During reset: PC_OUT=0, IMEM_REQ=0, IF_ID_VALID=0.
  - Requests at 0x0, 0x4, 0x8 on consecutive cycles.
  - IF_ID_PC follows 0x0, 0x4, 0x8 one cycle behind each request.
- **Wait states:** ACK delayed by 2 cycles for address 0x8.
  - IMEM_ADDR holds 0x8 for 3 cycles.
  - IF_ID_VALID=0 for 2 cycles, then PC=0x8 with valid=1.
- **Stall during ACK:** STALL=1 for 3 cycles starting on the 0x4 ACK.
  - IF/ID holds the 0x0 instruction and no request is made.
  - After STALL falls, IF_ID_PC=0x4 with the buffered instruction and PC_OUT=0x8.
- **Redirect priority:** BR_TAKEN=1 (target 0x100) and JMP=1 (target 0x200) in the same cycle.
  - Next PC_OUT=0x200 and IF_ID_VALID=0.
  - Adding EXC=1 in the same cycle gives PC_OUT=0x80.
- **Redirect while in HOLD with STALL=1**, target 0x40:
  - BUF is discarded and IF_ID_VALID=0.
  - The next request is at 0x40.
  - The stalled instruction never reaches IF/ID.
- **Wrap:** force PC=0xFFFF_FFFC with PC_PLUS4=0x0. The next PC_OUT is 0x0000_0000.
